// File: rtl/jt900h_busarb_pkg.sv
// Shared JT900H bus-arbiter constants: state encoding, wait-counter width and
// parameter range checks used by the arbiter and the core-side wrappers.
package jt900h_busarb_pkg;

    localparam int CNT_W = 4;

    localparam logic [1:0] ST_CPU  = 2'd0;
    localparam logic [1:0] ST_HAND = 2'd1;
    localparam logic [1:0] ST_DMA  = 2'd2;
    localparam logic [1:0] ST_BACK = 2'd3;

    typedef struct packed {
        logic [23:0] addr;
        logic [15:0] dout;
        logic [1:0]  we;
    } bus_req_t;

    function automatic bit wait_ok(int w);
        return (w >= 0) && (w <= 15);
    endfunction

    function automatic bit burst_ok(int b);
        return (b >= 1) && (b <= 15);
    endfunction

endpackage

// File: rtl/jt900h_waitcnt.sv
// Per-access wait-state counter: counts cen cycles up to WAIT, freezes while
// bus_wait is high and strobes done on the completing cen cycle.
module jt900h_waitcnt
    import jt900h_busarb_pkg::*;
#(
    parameter int WAIT = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic cen,
    input  logic clr,
    input  logic bus_wait,
    output logic done
);

    localparam logic [CNT_W-1:0] WAIT_C = CNT_W'(WAIT);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             at_wait;

    always_comb begin
        at_wait = (cnt_q == WAIT_C);
        done    = cen & ~clr & at_wait & ~bus_wait;
        cnt_d   = cnt_q;
        if (cen) begin
            if (clr || done) begin
                cnt_d = '0;
            end else if (!at_wait) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/jt900h_busarb.sv
// External bus arbiter between the JT900H core (stalled through cpu_cen) and
// the micro-DMA engine (req/gnt/ack handshake with bounded bursts).
module jt900h_busarb
    import jt900h_busarb_pkg::*;
#(
    parameter int WAIT     = 0,
    parameter int MAXBURST = 4
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        cen,
    output logic        cpu_cen,
    input  logic [23:0] cpu_addr,
    input  logic [15:0] cpu_dout,
    input  logic [1:0]  cpu_we,
    output logic [15:0] cpu_din,
    input  logic        dma_req,
    output logic        dma_gnt,
    output logic        dma_ack,
    input  logic [23:0] dma_addr,
    input  logic [15:0] dma_dout,
    input  logic [1:0]  dma_we,
    output logic [15:0] dma_din,
    output logic [23:0] bus_addr,
    output logic [15:0] bus_dout,
    output logic [1:0]  bus_we,
    input  logic [15:0] bus_din,
    input  logic        bus_wait
);

    if (!wait_ok(WAIT)) begin : g_bad_wait
        $error("jt900h_busarb: WAIT must be in 0..15");
    end
    if (!burst_ok(MAXBURST)) begin : g_bad_burst
        $error("jt900h_busarb: MAXBURST must be in 1..15");
    end

    localparam logic [CNT_W-1:0] BURST_C = CNT_W'(MAXBURST);

    logic [1:0]       st_q, st_d;
    logic [CNT_W-1:0] beats_q, beats_d;
    logic             fair_q, fair_d;
    logic             done, clr, in_dma, beat_live, hand_ok;
    bus_req_t         bus_sel;

    always_comb begin
        in_dma    = (st_q == ST_DMA);
        beat_live = in_dma & dma_req;
        // Turnaround cycles and a withdrawn DMA request keep the counter at 0,
        // so every new owner starts a fresh access.
        clr       = (st_q == ST_HAND) | (st_q == ST_BACK) | (in_dma & ~dma_req);
    end

    jt900h_waitcnt #(.WAIT(WAIT)) u_wcnt (
        .clk      (clk),
        .rst      (rst),
        .cen      (cen),
        .clr      (clr),
        .bus_wait (bus_wait),
        .done     (done)
    );

    always_comb begin
        st_d    = st_q;
        beats_d = beats_q;
        fair_d  = fair_q;
        // After BACK the core is owed an access; its completion pays it off.
        hand_ok = ~fair_q | done;
        if (cen) begin
            case (st_q)
                ST_CPU: begin
                    if (done) fair_d = 1'b0;
                    if (done && dma_req && hand_ok) st_d = ST_HAND;
                end
                ST_HAND: begin
                    st_d    = ST_DMA;
                    beats_d = '0;
                end
                ST_DMA: begin
                    if (!dma_req) begin
                        st_d = ST_BACK;
                    end else if (done) begin
                        beats_d = beats_q + 1'b1;
                        if (beats_q + 1'b1 == BURST_C) st_d = ST_BACK;
                    end
                end
                default: begin
                    st_d   = ST_CPU;
                    fair_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= ST_CPU;
            beats_q <= '0;
            fair_q  <= 1'b0;
        end else begin
            st_q    <= st_d;
            beats_q <= beats_d;
            fair_q  <= fair_d;
        end
    end

    // While rst is high the outputs already look like the CPU-owned idle bus.
    always_comb begin
        bus_sel = '{addr: cpu_addr, dout: cpu_dout, we: cpu_we};
        if (rst) begin
            bus_sel.we = 2'b00;
        end else begin
            case (st_q)
                ST_DMA:  bus_sel = '{addr: dma_addr, dout: dma_dout,
                                     we: beat_live ? dma_we : 2'b00};
                ST_CPU:  ;
                default: bus_sel.we = 2'b00;
            endcase
        end
    end

    assign bus_addr = bus_sel.addr;
    assign bus_dout = bus_sel.dout;
    assign bus_we   = bus_sel.we;
    assign cpu_din  = bus_din;
    assign dma_din  = bus_din;
    assign cpu_cen  = ~rst & (st_q == ST_CPU) & done;
    assign dma_gnt  = ~rst & in_dma;
    assign dma_ack  = ~rst & beat_live & done;

endmodule

// File: tb/tb_jt900h_busarb.sv
// Scenario bench for jt900h_busarb: expected bus beats are queued when driven
// and checked on the matching completion pulse.
`timescale 1ns/1ps
module tb_jt900h_busarb;

    localparam int W  = 1;
    localparam int MB = 4;

    typedef struct packed {
        logic [23:0] addr;
        logic [15:0] dout;
        logic [1:0]  we;
    } exp_t;

    logic        clk = 1'b0, rst = 1'b1, cen = 1'b1;
    logic        cpu_cen, dma_gnt, dma_ack;
    logic [23:0] cpu_addr = '0, dma_addr = '0, bus_addr;
    logic [15:0] cpu_dout = '0, dma_dout = '0, bus_dout, bus_din = '0;
    logic [15:0] cpu_din, dma_din;
    logic [1:0]  cpu_we = '0, dma_we = '0, bus_we;
    logic        dma_req = 1'b0, bus_wait = 1'b0;

    int   total = 0, bad = 0;
    exp_t sb_q[$];
    exp_t e_t;

    jt900h_busarb #(.WAIT(W), .MAXBURST(MB)) dut (
        .rst(rst), .clk(clk), .cen(cen), .cpu_cen(cpu_cen),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_we(cpu_we), .cpu_din(cpu_din),
        .dma_req(dma_req), .dma_gnt(dma_gnt), .dma_ack(dma_ack),
        .dma_addr(dma_addr), .dma_dout(dma_dout), .dma_we(dma_we), .dma_din(dma_din),
        .bus_addr(bus_addr), .bus_dout(bus_dout), .bus_we(bus_we),
        .bus_din(bus_din), .bus_wait(bus_wait)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; cen = 1'b1; dma_req = 1'b1;
        cpu_addr = 24'hABCDEF; cpu_we = 2'b11; dma_we = 2'b11; bus_din = 16'h5A5A;
        repeat (2) tick();
        @(negedge clk);
        total++;
        if ({cpu_cen, dma_gnt, dma_ack} !== 3'b000) begin
            bad++; $display("FAIL reset_ctl: got %b want 000", {cpu_cen, dma_gnt, dma_ack});
        end
        total++;
        if (bus_we !== 2'b00) begin bad++; $display("FAIL reset_we: got %b want 00", bus_we); end
        total++;
        if (bus_addr !== 24'hABCDEF) begin
            bad++; $display("FAIL reset_addr: got %h want abcdef", bus_addr);
        end
        total++;
        if ({cpu_din, dma_din} !== {16'h5A5A, 16'h5A5A}) begin
            bad++; $display("FAIL din_pass: got %h/%h want 5a5a", cpu_din, dma_din);
        end
        tick();
        rst = 1'b0; dma_req = 1'b0; cpu_we = 2'b01; dma_we = 2'b10;
    endtask

    task automatic test_cpu_only();
        for (int k = 0; k < 4 * (W + 1); k++) begin
            if (k % (W + 1) == 0) begin
                cpu_addr = 24'($urandom); cpu_dout = 16'($urandom);
                sb_q.push_back('{cpu_addr, cpu_dout, cpu_we});
            end
            @(negedge clk);
            total++;
            if (cpu_cen !== (k % (W + 1) == W)) begin
                bad++; $display("FAIL cpu_cen k=%0d: got %b want %b", k, cpu_cen, (k % (W + 1) == W));
            end
            total++;
            if (bus_addr !== cpu_addr || dma_gnt !== 1'b0 || bus_we !== cpu_we) begin
                bad++; $display("FAIL cpu_mux k=%0d: got %h/%b/%b want %h/0/%b", k, bus_addr, dma_gnt, bus_we, cpu_addr, cpu_we);
            end
            if (cpu_cen === 1'b1 && sb_q.size() > 0) begin
                e_t = sb_q.pop_front();
                total++;
                if ({bus_addr, bus_dout, bus_we} !== e_t) begin
                    bad++; $display("FAIL cpu_sb: got %h/%h want %h/%h", bus_addr, bus_dout, e_t.addr, e_t.dout);
                end
            end
            tick();
        end
    endtask

    task automatic test_dma_burst();
        dma_req = 1'b1;
        for (int k = 0; k <= W; k++) begin
            @(negedge clk);
            total++;
            if ({dma_gnt, cpu_cen} !== {1'b0, (k == W)}) begin
                bad++; $display("FAIL burst_pre k=%0d: got gnt=%b cen=%b", k, dma_gnt, cpu_cen);
            end
            tick();
        end
        @(negedge clk);
        total++;
        if ({dma_gnt, cpu_cen, bus_we} !== 4'b0000) begin
            bad++; $display("FAIL burst_hand: got gnt=%b cen=%b we=%b want 0/0/00", dma_gnt, cpu_cen, bus_we);
        end
        tick();
        for (int b = 0; b < MB; b++) begin
            dma_addr = 24'h800000 + 24'(b * 2); dma_dout = 16'($urandom);
            sb_q.push_back('{dma_addr, dma_dout, dma_we});
            for (int k = 0; k <= W; k++) begin
                @(negedge clk);
                total++;
                if ({dma_gnt, dma_ack, cpu_cen} !== {1'b1, (k == W), 1'b0}) begin
                    bad++; $display("FAIL burst_beat b=%0d k=%0d: got gnt=%b ack=%b cen=%b", b, k, dma_gnt, dma_ack, cpu_cen);
                end
                if (dma_ack === 1'b1 && sb_q.size() > 0) begin
                    e_t = sb_q.pop_front();
                    total++;
                    if ({bus_addr, bus_dout, bus_we} !== e_t) begin
                        bad++; $display("FAIL burst_sb b=%0d: got %h/%h/%b want %h/%h/%b", b, bus_addr, bus_dout, bus_we, e_t.addr, e_t.dout, e_t.we);
                    end
                end
                tick();
            end
        end
        @(negedge clk);
        total++;
        if ({dma_gnt, dma_ack, bus_we} !== 4'b0000) begin
            bad++; $display("FAIL burst_back: got gnt=%b ack=%b we=%b want 0/0/00", dma_gnt, dma_ack, bus_we);
        end
        tick();
        for (int k = 0; k <= W; k++) begin
            @(negedge clk);
            total++;
            if ({dma_gnt, cpu_cen} !== {1'b0, (k == W)}) begin
                bad++; $display("FAIL fair_cpu k=%0d: got gnt=%b cen=%b", k, dma_gnt, cpu_cen);
            end
            tick();
        end
        @(negedge clk);
        total++;
        if ({dma_gnt, bus_we} !== 3'b000) begin
            bad++; $display("FAIL fair_hand: got gnt=%b we=%b want 0/00", dma_gnt, bus_we);
        end
        tick();
        dma_req = 1'b0;
        @(negedge clk);
        total++;
        if ({dma_gnt, dma_ack, bus_we} !== 4'b1000) begin
            bad++; $display("FAIL idle_dma: got gnt=%b ack=%b we=%b want 1/0/00", dma_gnt, dma_ack, bus_we);
        end
        tick();
        @(negedge clk);
        total++;
        if ({dma_gnt, bus_we} !== 3'b000) begin
            bad++; $display("FAIL idle_back: got gnt=%b we=%b want 0/00", dma_gnt, bus_we);
        end
        tick();
    endtask

    task automatic test_ext_wait();
        dma_req = 1'b1;
        repeat (W + 2) tick();
        dma_addr = 24'h123456; dma_dout = 16'hBEEF;
        sb_q.push_back('{dma_addr, dma_dout, dma_we});
        for (int k = 0; k <= W + 5; k++) begin
            bus_wait = (k >= W) && (k < W + 5);
            @(negedge clk);
            total++;
            if ({dma_gnt, dma_ack} !== {1'b1, (k == W + 5)}) begin
                bad++; $display("FAIL wait_ack k=%0d: got gnt=%b ack=%b", k, dma_gnt, dma_ack);
            end
            if (bus_wait) begin
                total++;
                if (dut.u_wcnt.cnt_q !== 4'(W)) begin
                    bad++; $display("FAIL wait_cnt k=%0d: got %0d want %0d", k, dut.u_wcnt.cnt_q, W);
                end
            end
            if (dma_ack === 1'b1 && sb_q.size() > 0) begin
                e_t = sb_q.pop_front();
                total++;
                if ({bus_addr, bus_dout, bus_we} !== e_t) begin
                    bad++; $display("FAIL wait_sb: got %h/%h want %h/%h", bus_addr, bus_dout, e_t.addr, e_t.dout);
                end
            end
            tick();
        end
        bus_wait = 1'b0; dma_req = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_early_release();
        int acks = 0;
        dma_req = 1'b1;
        repeat (W + 2) tick();
        for (int b = 0; b < 3; b++) begin
            dma_addr = 24'h400000 + 24'(b); dma_dout = 16'(b + 16'h0100);
            if (b < 2) sb_q.push_back('{dma_addr, dma_dout, dma_we});
            for (int k = 0; k <= W; k++) begin
                if (b == 2 && k == W) dma_req = 1'b0;
                @(negedge clk);
                if (dma_ack === 1'b1) begin
                    acks++;
                    if (sb_q.size() > 0) begin
                        e_t = sb_q.pop_front();
                        total++;
                        if ({bus_addr, bus_dout} !== {e_t.addr, e_t.dout}) begin
                            bad++; $display("FAIL early_sb: got %h want %h", bus_addr, e_t.addr);
                        end
                    end
                end
                if (b == 2 && k == W) begin
                    total++;
                    if ({dma_gnt, dma_ack, bus_we} !== 4'b1000) begin
                        bad++; $display("FAIL early_abandon: got gnt=%b ack=%b we=%b want 1/0/00", dma_gnt, dma_ack, bus_we);
                    end
                end
                tick();
            end
        end
        total++;
        if (acks !== 2) begin bad++; $display("FAIL early_acks: got %0d want 2", acks); end
        @(negedge clk);
        total++;
        if ({dma_gnt, bus_we} !== 3'b000) begin
            bad++; $display("FAIL early_back: got gnt=%b we=%b want 0/00", dma_gnt, bus_we);
        end
        tick();
        for (int k = 0; k <= W; k++) begin
            @(negedge clk);
            total++;
            if (cpu_cen !== (k == W)) begin
                bad++; $display("FAIL early_resume k=%0d: got %b want %b", k, cpu_cen, (k == W));
            end
            tick();
        end
    endtask

    task automatic test_cen_gating();
        localparam int END_E = W + 2 + MB * (W + 1);
        int  e = 0;
        int  off;
        logic in_dma_e, exp_ack;
        dma_req = 1'b1;
        for (int c = 0; c < 400 && e <= END_E; c++) begin
            cen = 1'($urandom_range(0, 1));
            in_dma_e = (e >= W + 2) && (e < END_E);
            off = e - (W + 2);
            if (cen && in_dma_e && (off % (W + 1) == 0)) begin
                dma_addr = 24'($urandom); dma_dout = 16'($urandom);
                sb_q.push_back('{dma_addr, dma_dout, dma_we});
            end
            if (cen && e == END_E) dma_req = 1'b0;
            exp_ack = cen && in_dma_e && (off % (W + 1) == W);
            @(negedge clk);
            total++;
            if ({cpu_cen, dma_ack, dma_gnt} !== {(cen && e == W), exp_ack, in_dma_e}) begin
                bad++; $display("FAIL cen_gate c=%0d e=%0d cen=%b: got cen=%b ack=%b gnt=%b", c, e, cen, cpu_cen, dma_ack, dma_gnt);
            end
            if (dma_ack === 1'b1 && sb_q.size() > 0) begin
                e_t = sb_q.pop_front();
                total++;
                if ({bus_addr, bus_dout, bus_we} !== e_t) begin
                    bad++; $display("FAIL cen_sb e=%0d: got %h want %h", e, bus_addr, e_t.addr);
                end
            end
            tick();
            if (cen) e++;
        end
        total++;
        if (e <= END_E) begin bad++; $display("FAIL cen_timeout: got e=%0d want >%0d", e, END_E); end
        cen = 1'b1;
    endtask

    task automatic test_reset_mid_burst();
        int acks = 0;
        dma_req = 1'b1;
        repeat (W + 2) tick();
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({dma_gnt, dma_ack, cpu_cen, bus_we} !== 5'b00000) begin
            bad++; $display("FAIL rst_mid: got gnt=%b ack=%b cen=%b we=%b", dma_gnt, dma_ack, cpu_cen, bus_we);
        end
        tick();
        rst = 1'b0; dma_req = 1'b0;
        for (int k = 0; k <= W; k++) begin
            @(negedge clk);
            if (dma_ack === 1'b1) acks++;
            total++;
            if ({dma_gnt, cpu_cen, bus_we} !== {1'b0, (k == W), cpu_we}) begin
                bad++; $display("FAIL rst_after k=%0d: got gnt=%b cen=%b we=%b", k, dma_gnt, cpu_cen, bus_we);
            end
            tick();
        end
        total++;
        if (acks !== 0) begin bad++; $display("FAIL rst_acks: got %0d want 0", acks); end
    endtask

    initial begin
        test_reset();
        test_cpu_only();
        test_dma_burst();
        test_ext_wait();
        test_early_release();
        test_cen_gating();
        test_reset_mid_burst();
        total++;
        if (sb_q.size() !== 0) begin bad++; $display("FAIL sb_left: got %0d want 0", sb_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
